dma_priority_arbiter: RTL and testbench

Four-channel request arbiter for the 8237-style DMA controller. It sits between the external `DREQ`/`HLDA` pins and the timing-control state machine. It merges hardware and software requests, applies masking, and runs the `HRQ`/`HLDA` bus-hold handshake. It selects one channel under fixed or rotating priority, drives `DACK`, and hands the winning channel to timing control until that block reports end of service.

---
 rtl/dma_pkg.sv | 48 ++++
 rtl/dma_priority_arbiter.sv | 140 ++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the 8237-style DMA controller request arbiter.
//   arb_state_t       : arbiter FSM states (IDLE, REQ, GRANT)
//   DEFAULT_PRIORITY  : fixed-priority order, channel 0 highest, 3 lowest
//   NUM_CH            : channel count (only 4 is supported)
//   pickChannel       : first requesting channel in a packed priority order
//   rotateAfter       : priority order after channel ch has been serviced
// A priority order packs four 2-bit channel indices; [1:0] is the highest
// priority slot and [7:6] the lowest.
// ---------------------------------------------------------------------------
package dma_pkg;

  localparam int NUM_CH = 4;

  localparam logic [7:0] DEFAULT_PRIORITY = 8'b11_10_01_00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

  // Scans the order from the highest-priority slot down and returns the first
  // channel whose request bit is set. Callers only use the result when at
  // least one request bit is set; otherwise the top slot is returned.
  function automatic logic [1:0] pickChannel(input logic [7:0] order,
                                             input logic [3:0] req);
    logic [1:0] ch;
    logic       found;
    ch    = order[1:0];
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[order[2*i +: 2]]) begin
        ch    = order[2*i +: 2];
        found = 1'b1;
      end
    end
    return ch;
  endfunction

  // The serviced channel drops to the lowest slot and the others follow it
  // cyclically: order becomes (ch+1, ch+2, ch+3, ch) mod 4.
  function automatic logic [7:0] rotateAfter(input logic [1:0] ch);
    return {ch, ch + 2'd3, ch + 2'd2, ch + 2'd1};
  endfunction

endpackage

// File: rtl/dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter
// Four-channel DMA request arbiter. Merges hardware and software requests,
// applies masking, runs the HRQ/HLDA bus-hold handshake, selects a channel
// under fixed or rotating priority and holds the grant until timing control
// reports end of service.
// Ports:
//   CLK, RESET         clock and synchronous active-high reset
//   DREQ               hardware requests (masked by maskReg)
//   softwareReq        register-file requests (never masked)
//   maskReg            per-channel DREQ mask
//   controllerDisable  blocks new arbitration when high
//   priorityType       0 = fixed priority, 1 = rotating priority
//   HLDA               hold acknowledge from the CPU
//   cycleDone          one-cycle end-of-service pulse from timing control
//   HRQ                hold request to the CPU
//   DACK               one-hot channel acknowledge
//   grantValid         a channel is granted
//   activeChannel      index of the granted channel
//   priorityOrder      current packed priority order
// ---------------------------------------------------------------------------
module dma_priority_arbiter #(
  parameter int NUM_CH = dma_pkg::NUM_CH
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] softwareReq,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              controllerDisable,
  input  logic              priorityType,
  input  logic              HLDA,
  input  logic              cycleDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [1:0]        activeChannel,
  output logic [7:0]        priorityOrder
);

  import dma_pkg::*;

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              hrq_d;
  logic [NUM_CH-1:0] dack_d;
  logic              grant_valid_d;
  logic [1:0]        active_channel_d;
  logic [7:0]        priority_order_d;

  logic [NUM_CH-1:0] eff_req;
  logic [1:0]        winner;

  // Masking applies only to the hardware pins; software requests always count.
  assign eff_req = (DREQ & ~maskReg) | softwareReq;

  // Winner is evaluated against the request seen at the HLDA edge, not the
  // request that originally raised HRQ.
  assign winner = pickChannel(priorityOrder, eff_req);

  always_comb begin
    state_d          = state_q;
    hrq_d            = HRQ;
    dack_d           = DACK;
    grant_valid_d    = grantValid;
    active_channel_d = activeChannel;
    priority_order_d = priorityOrder;

    case (state_q)
      IDLE: begin
        if ((eff_req != '0) && !controllerDisable) begin
          state_d = REQ;
          hrq_d   = 1'b1;
        end
      end

      REQ: begin
        if (eff_req == '0) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end else if (HLDA && !controllerDisable) begin
          state_d          = GRANT;
          active_channel_d = winner;
          dack_d           = {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
          grant_valid_d    = 1'b1;
        end
      end

      GRANT: begin
        // cycleDone wins over a simultaneous HLDA drop: normal completion.
        if (cycleDone) begin
          state_d       = IDLE;
          hrq_d         = 1'b0;
          dack_d        = '0;
          grant_valid_d = 1'b0;
          if (priorityType) begin
            priority_order_d = rotateAfter(activeChannel);
          end
        end else if (!HLDA) begin
          state_d       = IDLE;
          hrq_d         = 1'b0;
          dack_d        = '0;
          grant_valid_d = 1'b0;
        end
      end

      default: begin
        state_d       = IDLE;
        hrq_d         = 1'b0;
        dack_d        = '0;
        grant_valid_d = 1'b0;
      end
    endcase

    // Fixed mode pins the order every cycle, so switching to rotating mode
    // always starts from the default order unless rotation already happened.
    if (!priorityType) begin
      priority_order_d = DEFAULT_PRIORITY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      HRQ           <= 1'b0;
      DACK          <= '0;
      grantValid    <= 1'b0;
      activeChannel <= 2'd0;
      priorityOrder <= DEFAULT_PRIORITY;
    end else begin
      state_q       <= state_d;
      HRQ           <= hrq_d;
      DACK          <= dack_d;
      grantValid    <= grant_valid_d;
      activeChannel <= active_channel_d;
      priorityOrder <= priority_order_d;
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_priority_arbiter
// Self-checking bench for dma_priority_arbiter: a table of per-cycle vectors
// for fixed priority, hand-written multi-cycle corner sequences, and a
// randomized run compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] softwareReq;
  logic [3:0] maskReg;
  logic       controllerDisable;
  logic       priorityType;
  logic       HLDA;
  logic       cycleDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] activeChannel;
  logic [7:0] priorityOrder;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 waiting for HLDA, 2 holding a grant.
  int         m_phase;
  int         m_prio[4];
  int         m_ch;
  bit         m_hrq;
  bit         m_gv;
  logic [3:0] m_dack;

  typedef struct {
    logic       rst;
    logic [3:0] dreq;
    logic       hlda;
    logic       done;
    logic       hrq;
    logic [3:0] dack;
    logic       gv;
    logic [7:0] order;
  } vec_t;

  always #5 CLK = ~CLK;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .DREQ              (DREQ),
    .softwareReq       (softwareReq),
    .maskReg           (maskReg),
    .controllerDisable (controllerDisable),
    .priorityType      (priorityType),
    .HLDA              (HLDA),
    .cycleDone         (cycleDone),
    .HRQ               (HRQ),
    .DACK              (DACK),
    .grantValid        (grantValid),
    .activeChannel     (activeChannel),
    .priorityOrder     (priorityOrder)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] dreq, input logic hlda,
                              input logic done, input logic hrq, input logic [3:0] dack,
                              input logic gv, input logic [7:0] order);
    vec_t v;
    v.rst = rst; v.dreq = dreq; v.hlda = hlda; v.done = done;
    v.hrq = hrq; v.dack = dack; v.gv = gv; v.order = order;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    RESET             = v.rst;
    DREQ              = v.dreq;
    HLDA              = v.hlda;
    cycleDone         = v.done;
    softwareReq       = 4'b0000;
    maskReg           = 4'b0000;
    controllerDisable = 1'b0;
    priorityType      = 1'b0;
  endtask

  function automatic logic [7:0] modelOrder();
    return {2'(m_prio[3]), 2'(m_prio[2]), 2'(m_prio[1]), 2'(m_prio[0])};
  endfunction

  // Advances the model by one clock edge using the inputs present at the edge.
  task automatic modelStep();
    logic [3:0] eff;
    int         win;
    int         nxt[4];
    eff = (DREQ & ~maskReg) | softwareReq;
    if (RESET) begin
      m_phase = 0; m_hrq = 0; m_gv = 0; m_dack = 4'b0000; m_ch = 0;
      for (int i = 0; i < 4; i++) m_prio[i] = i;
      return;
    end
    nxt = m_prio;
    case (m_phase)
      0: begin
        if (eff != 4'b0000 && !controllerDisable) begin
          m_phase = 1; m_hrq = 1;
        end
      end
      1: begin
        if (eff == 4'b0000) begin
          m_phase = 0; m_hrq = 0;
        end else if (HLDA && !controllerDisable) begin
          win = -1;
          for (int i = 0; i < 4; i++) if (win < 0 && eff[m_prio[i]]) win = m_prio[i];
          m_ch = win; m_dack = 4'b0001 << win; m_gv = 1; m_phase = 2;
        end
      end
      default: begin
        if (cycleDone) begin
          m_phase = 0; m_hrq = 0; m_gv = 0; m_dack = 4'b0000;
          if (priorityType) for (int i = 0; i < 4; i++) nxt[i] = (m_ch + 1 + i) % 4;
        end else if (!HLDA) begin
          m_phase = 0; m_hrq = 0; m_gv = 0; m_dack = 4'b0000;
        end
      end
    endcase
    if (!priorityType) for (int i = 0; i < 4; i++) nxt[i] = i;
    m_prio = nxt;
  endtask

  // One clock edge: update the model alongside the DUT, then compare just
  // after the edge once the DUT outputs have settled.
  task automatic tick();
    @(posedge CLK);
    modelStep();
    #1;
    checkOutput("model_hrq", 32'(HRQ), 32'(m_hrq));
    checkOutput("model_dack", 32'(DACK), 32'(m_dack));
    checkOutput("model_grant_valid", 32'(grantValid), 32'(m_gv));
    checkOutput("model_priority_order", 32'(priorityOrder), 32'(modelOrder()));
    if (m_gv) checkOutput("model_active_channel", 32'(activeChannel), 32'(m_ch));
    checkOutput("dack_onehot", 32'($countones(DACK) <= 1), 32'd1);
  endtask

  initial begin
    vec_t       vecs[12];
    logic [7:0] rot_exp[4];
    logic [3:0] exp_dack;

    m_phase = 0; m_hrq = 0; m_gv = 0; m_dack = 4'b0000; m_ch = 0;
    for (int i = 0; i < 4; i++) m_prio[i] = i;
    RESET = 1'b1; DREQ = 4'b0000; softwareReq = 4'b0000; maskReg = 4'b0000;
    controllerDisable = 1'b0; priorityType = 1'b0; HLDA = 1'b0; cycleDone = 1'b0;

    // Fixed priority: rst, DREQ, HLDA, cycleDone -> HRQ, DACK, grantValid, order
    vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hE4);
    vecs[1]  = mk(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hE4);
    vecs[2]  = mk(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hE4);
    vecs[3]  = mk(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hE4);
    vecs[4]  = mk(1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hE4);
    vecs[5]  = mk(1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hE4);
    vecs[6]  = mk(1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 8'hE4);
    vecs[7]  = mk(1'b0, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hE4);
    vecs[8]  = mk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hE4);
    vecs[9]  = mk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hE4);
    vecs[10] = mk(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hE4);
    vecs[11] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hE4);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_hrq", i), 32'(HRQ), 32'(vecs[i].hrq));
      checkOutput($sformatf("vec%0d_dack", i), 32'(DACK), 32'(vecs[i].dack));
      checkOutput($sformatf("vec%0d_grant_valid", i), 32'(grantValid), 32'(vecs[i].gv));
      checkOutput($sformatf("vec%0d_order", i), 32'(priorityOrder), 32'(vecs[i].order));
    end

    // Rotating priority: four grants walk through every channel.
    rot_exp[0] = 8'h39; rot_exp[1] = 8'h4E; rot_exp[2] = 8'h93; rot_exp[3] = 8'hE4;
    RESET = 1'b1; tick(); RESET = 1'b0;
    priorityType = 1'b1; DREQ = 4'b1111; HLDA = 1'b1; cycleDone = 1'b0;
    for (int g = 0; g < 4; g++) begin
      tick();
      checkOutput("rot_hrq", 32'(HRQ), 32'd1);
      tick();
      exp_dack = 4'b0001 << g;
      checkOutput("rot_dack", 32'(DACK), 32'(exp_dack));
      checkOutput("rot_active_channel", 32'(activeChannel), 32'(g));
      cycleDone = 1'b1;
      tick();
      checkOutput("rot_order", 32'(priorityOrder), 32'(rot_exp[g]));
      cycleDone = 1'b0;
    end

    // Masked DREQ never raises HRQ; a software request gets through.
    RESET = 1'b1; tick(); RESET = 1'b0;
    priorityType = 1'b0; maskReg = 4'b0001; DREQ = 4'b0001; HLDA = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("mask_hrq_low", 32'(HRQ), 32'd0);
    end
    softwareReq = 4'b0001;
    tick();
    checkOutput("sw_hrq", 32'(HRQ), 32'd1);
    tick();
    checkOutput("sw_dack", 32'(DACK), 32'h1);
    cycleDone = 1'b1; softwareReq = 4'b0000;
    tick();
    cycleDone = 1'b0; DREQ = 4'b0000; maskReg = 4'b0000;

    // Request withdrawn while waiting for HLDA.
    RESET = 1'b1; tick(); RESET = 1'b0;
    DREQ = 4'b0100; HLDA = 1'b0;
    tick();
    checkOutput("withdraw_hrq_up", 32'(HRQ), 32'd1);
    DREQ = 4'b0000;
    tick();
    checkOutput("withdraw_hrq_down", 32'(HRQ), 32'd0);
    HLDA = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("withdraw_no_dack", 32'(DACK), 32'd0);
    end

    // HLDA drops mid-grant: abort without rotation; request changes ignored.
    RESET = 1'b1; tick(); RESET = 1'b0;
    priorityType = 1'b1; DREQ = 4'b0100; HLDA = 1'b1;
    tick(); tick();
    checkOutput("abort_dack_before", 32'(DACK), 32'h4);
    DREQ = 4'b0001;
    tick();
    checkOutput("grant_ignores_dreq", 32'(DACK), 32'h4);
    HLDA = 1'b0;
    tick();
    checkOutput("abort_dack", 32'(DACK), 32'd0);
    checkOutput("abort_grant_valid", 32'(grantValid), 32'd0);
    checkOutput("abort_hrq", 32'(HRQ), 32'd0);
    checkOutput("abort_order", 32'(priorityOrder), 32'hE4);

    // cycleDone and HLDA falling together still rotate.
    DREQ = 4'b0100; HLDA = 1'b1;
    tick(); tick();
    checkOutput("simul_dack_before", 32'(DACK), 32'h4);
    HLDA = 1'b0; cycleDone = 1'b1;
    tick();
    checkOutput("simul_order", 32'(priorityOrder), 32'h93);
    checkOutput("simul_dack", 32'(DACK), 32'd0);

    // Reset during a grant restores every reset value.
    cycleDone = 1'b0; HLDA = 1'b1;
    tick(); tick();
    checkOutput("rst_grant_dack_before", 32'(DACK), 32'h4);
    RESET = 1'b1;
    tick();
    checkOutput("rst_grant_dack", 32'(DACK), 32'd0);
    checkOutput("rst_grant_hrq", 32'(HRQ), 32'd0);
    checkOutput("rst_grant_order", 32'(priorityOrder), 32'hE4);
    checkOutput("rst_grant_valid", 32'(grantValid), 32'd0);
    RESET = 1'b0; DREQ = 4'b0000;

    // Randomized traffic against the model.
    priorityType = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      RESET             = ($urandom_range(0, 99) == 0);
      DREQ              = 4'($urandom);
      softwareReq       = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      maskReg           = 4'($urandom);
      controllerDisable = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) priorityType = ~priorityType;
      HLDA              = ($urandom_range(0, 9) < 7);
      cycleDone         = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
